fp_unit_sp: RTL and testbench

//  Single-precision (IEEE-754 binary32) FP execution subset: compares (FLE/FLT/FEQ),
//  int->float (i32/ui32) and float->int (i32/ui32) conversions with RISC-V fflags.

---
 rtl/fp_unit_sp.sv | 225 ++++++++++++++++++++++
 tb/tb_fp_unit_sp.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fp_unit_sp.sv
// Single-precision FP execute subset: FLE/FLT/FEQ compares and i32/ui32 <-> f32
// conversions with RISC-V fflags. One op per cycle, results registered (latency 1).
module fp_unit_sp (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic [1:0]  fmt,
    input  logic [2:0]  rm,
    input  logic        fcmp,
    input  logic        fcvt_i2f,
    input  logic        fcvt_f2i,
    input  logic [1:0]  fcvt_op,
    input  logic        enable,
    output logic [31:0] result,
    output logic [4:0]  flags,
    output logic        ready
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned SIG_W  = 24;
    localparam int unsigned FLAG_W = 5;
    localparam int unsigned NV     = 4;
    localparam int unsigned NX     = 0;

    // Round-increment decision shared by both conversion directions.
    function automatic logic round_up(input logic [2:0] mode, input logic neg,
                                      input logic lsb, input logic g, input logic s);
        case (mode)
            3'd1:    round_up = 1'b0;
            3'd2:    round_up = neg & (g | s);
            3'd3:    round_up = ~neg & (g | s);
            3'd4:    round_up = g;
            default: round_up = g & (s | lsb);
        endcase
    endfunction

    function automatic logic [4:0] lzc32(input logic [XLEN-1:0] v);
        lzc32 = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) lzc32 = 5'(31 - i);
        end
    endfunction

    // ---------------- compare ----------------
    logic             a_nan, b_nan, a_snan, b_snan, any_nan, both_zero;
    logic             cmp_eq, cmp_lt;
    logic [XLEN-1:0]  cmp_res;
    logic [FLAG_W-1:0] cmp_flg;

    always_comb begin
        a_nan     = (data1[30:23] == 8'hFF) && (data1[22:0] != 23'd0);
        b_nan     = (data2[30:23] == 8'hFF) && (data2[22:0] != 23'd0);
        a_snan    = a_nan && !data1[22];
        b_snan    = b_nan && !data2[22];
        any_nan   = a_nan || b_nan;
        both_zero = (data1[30:0] == 31'd0) && (data2[30:0] == 31'd0);
        cmp_eq    = !any_nan && ((data1 == data2) || both_zero);
        cmp_lt    = 1'b0;
        if (!any_nan && !both_zero) begin
            if (data1[31] != data2[31])
                cmp_lt = data1[31];
            else if (!data1[31])
                cmp_lt = data1[30:0] < data2[30:0];
            else
                cmp_lt = data1[30:0] > data2[30:0];
        end
        cmp_res = '0;
        cmp_flg = '0;
        case (rm)
            3'd0: begin
                cmp_res[0]   = cmp_lt || cmp_eq;
                cmp_flg[NV]  = any_nan;
            end
            3'd1: begin
                cmp_res[0]   = cmp_lt;
                cmp_flg[NV]  = any_nan;
            end
            default: begin
                cmp_res[0]   = cmp_eq;
                cmp_flg[NV]  = a_snan || b_snan;
            end
        endcase
    end

    // ---------------- int -> float ----------------
    logic              i2f_neg, i2f_g, i2f_s, i2f_inc;
    logic [XLEN-1:0]   i2f_mag, i2f_norm;
    logic [4:0]        i2f_lz;
    logic [SIG_W-1:0]  i2f_sig;
    logic [SIG_W:0]    i2f_sum;
    logic [EXP_W-1:0]  i2f_exp;
    logic [XLEN-1:0]   i2f_res;
    logic [FLAG_W-1:0] i2f_flg;

    always_comb begin
        i2f_neg  = !fcvt_op[0] && data1[31];
        i2f_mag  = i2f_neg ? 32'(-data1) : data1;
        i2f_lz   = lzc32(i2f_mag);
        i2f_norm = i2f_mag << i2f_lz;
        i2f_sig  = i2f_norm[31:8];
        i2f_g    = i2f_norm[7];
        i2f_s    = |i2f_norm[6:0];
        i2f_inc  = round_up(rm, i2f_neg, i2f_sig[0], i2f_g, i2f_s);
        i2f_sum  = {1'b0, i2f_sig} + 25'(i2f_inc);
        // Carry-out leaves the mantissa field all zero; only the exponent moves.
        i2f_exp  = 8'd158 - 8'(i2f_lz) + 8'(i2f_sum[SIG_W]);
        i2f_res  = '0;
        i2f_flg  = '0;
        if (i2f_mag != 32'd0) begin
            i2f_res     = {i2f_neg, i2f_exp, i2f_sum[22:0]};
            i2f_flg[NX] = i2f_g | i2f_s;
        end
    end

    // ---------------- float -> int ----------------
    logic              f_neg, f_nan, f_big, f_uns, f_g, f_s, f_inc, f_nx;
    logic [EXP_W-1:0]  f_exp;
    logic [SIG_W-1:0]  f_sig;
    logic [5:0]        f_shamt;
    logic [55:0]       f_w;
    logic [XLEN-1:0]   f_int;
    logic [XLEN:0]     f_mag;
    logic [XLEN-1:0]   f2i_res;
    logic [FLAG_W-1:0] f2i_flg;

    always_comb begin
        f_neg   = data1[31];
        f_exp   = data1[30:23];
        f_uns   = fcvt_op[0];
        f_nan   = (f_exp == 8'hFF) && (data1[22:0] != 23'd0);
        f_big   = f_exp >= 8'd159;
        f_sig   = {1'b1, data1[22:0]};
        f_shamt = 6'(f_exp - 8'd126);
        f_w     = '0;
        f_int   = '0;
        f_g     = 1'b0;
        f_s     = 1'b0;
        // Fixed point with 24 fraction bits: exponent 126 (value in [0.5,1)) is shift 0.
        if (f_exp >= 8'd126 && f_exp <= 8'd158) begin
            f_w   = {32'd0, f_sig} << f_shamt;
            f_int = f_w[55:24];
            f_g   = f_w[23];
            f_s   = |f_w[22:0];
        end else if (f_exp != 8'd0) begin
            f_s   = 1'b1;
        end
        f_inc   = round_up(rm, f_neg, f_int[0], f_g, f_s);
        f_mag   = {1'b0, f_int} + 33'(f_inc);
        f_nx    = f_g | f_s;
        f2i_res = '0;
        f2i_flg = '0;
        if (f_nan) begin
            f2i_res     = f_uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
            f2i_flg[NV] = 1'b1;
        end else if (f_exp == 8'd0) begin
            f2i_flg[NX] = data1[22:0] != 23'd0;
        end else if (f_big) begin
            if (f_uns) f2i_res = f_neg ? 32'd0 : 32'hFFFF_FFFF;
            else       f2i_res = f_neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
            f2i_flg[NV] = 1'b1;
        end else if (f_uns) begin
            if (!f_neg && f_mag[XLEN]) begin
                f2i_res     = 32'hFFFF_FFFF;
                f2i_flg[NV] = 1'b1;
            end else if (!f_neg) begin
                f2i_res     = f_mag[31:0];
                f2i_flg[NX] = f_nx;
            end else if (f_mag != 33'd0) begin
                f2i_flg[NV] = 1'b1;
            end else begin
                f2i_flg[NX] = f_nx;
            end
        end else begin
            if (!f_neg && f_mag > 33'h0_7FFF_FFFF) begin
                f2i_res     = 32'h7FFF_FFFF;
                f2i_flg[NV] = 1'b1;
            end else if (f_neg && f_mag > 33'h0_8000_0000) begin
                f2i_res     = 32'h8000_0000;
                f2i_flg[NV] = 1'b1;
            end else begin
                f2i_res     = f_neg ? 32'(-f_mag[31:0]) : f_mag[31:0];
                f2i_flg[NX] = f_nx;
            end
        end
    end

    // ---------------- output select and registers ----------------
    logic [XLEN-1:0]   result_d;
    logic [FLAG_W-1:0] flags_d;
    logic              unused_ok;

    assign unused_ok = ^{fmt, fcvt_op[1], i2f_sum[SIG_W-1]};

    always_comb begin
        result_d = '0;
        flags_d  = '0;
        if (enable) begin
            if (fcmp) begin
                result_d = cmp_res;
                flags_d  = cmp_flg;
            end else if (fcvt_i2f) begin
                result_d = i2f_res;
                flags_d  = i2f_flg;
            end else if (fcvt_f2i) begin
                result_d = f2i_res;
                flags_d  = f2i_flg;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result <= '0;
            flags  <= '0;
            ready  <= 1'b0;
        end else begin
            result <= result_d;
            flags  <= flags_d;
            ready  <= enable;
        end
    end

endmodule

// File: tb/tb_fp_unit_sp.sv
// Directed bench for fp_unit_sp: hand-computed compare/convert vectors, one op per cycle.
module tb_fp_unit_sp;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data1 = '0;
    logic [31:0] data2 = '0;
    logic [1:0]  fmt = '0;
    logic [2:0]  rm = '0;
    logic        fcmp = 1'b0;
    logic        fcvt_i2f = 1'b0;
    logic        fcvt_f2i = 1'b0;
    logic [1:0]  fcvt_op = '0;
    logic        enable = 1'b0;
    logic [31:0] result;
    logic [4:0]  flags;
    logic        ready;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [2:0] CMP = 3'b100;
    localparam logic [2:0] I2F = 3'b010;
    localparam logic [2:0] F2I = 3'b001;

    fp_unit_sp dut (
        .clock(clock), .reset(reset), .data1(data1), .data2(data2), .fmt(fmt), .rm(rm),
        .fcmp(fcmp), .fcvt_i2f(fcvt_i2f), .fcvt_f2i(fcvt_f2i), .fcvt_op(fcvt_op),
        .enable(enable), .result(result), .flags(flags), .ready(ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic er, input logic [4:0] ef,
                         input logic [31:0] eres);
        n_cmp++;
        assert ({ready, flags, result} === {er, ef, eres}) else begin
            n_err++;
            $error("FAIL %s: got ready=%0b flags=%02h result=%08h, expected ready=%0b flags=%02h result=%08h",
                   tag, ready, flags, result, er, ef, eres);
        end
    endtask

    // Drive one op, let it register, check it one cycle later.
    task automatic run(input string tag, input logic [2:0] sel, input logic en,
                       input logic uns, input logic [2:0] mode, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eres, input logic [4:0] ef);
        {fcmp, fcvt_i2f, fcvt_f2i} = sel;
        enable  = en;
        fcvt_op = {1'b0, uns};
        rm      = mode;
        data1   = a;
        data2   = b;
        @(posedge clock);
        #1;
        check(tag, en, ef, eres);
    endtask

    initial begin
        #12;
        check("reset_state", 1'b0, 5'h00, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // compares
        run("flt_1_lt_2",   CMP, 1, 0, 3'd1, 32'h3F800000, 32'h40000000, 32'd1, 5'h00);
        run("feq_negzero",  CMP, 1, 0, 3'd2, 32'h80000000, 32'h00000000, 32'd1, 5'h00);
        run("feq_qnan",     CMP, 1, 0, 3'd2, 32'h7FC00000, 32'h3F800000, 32'd0, 5'h00);
        run("fle_qnan",     CMP, 1, 0, 3'd0, 32'h7FC00000, 32'h3F800000, 32'd0, 5'h10);
        run("feq_snan",     CMP, 1, 0, 3'd2, 32'h7F800001, 32'h3F800000, 32'd0, 5'h10);
        run("flt_neg",      CMP, 1, 0, 3'd1, 32'hBF800000, 32'hC0000000, 32'd0, 5'h00);
        run("fle_neg",      CMP, 1, 0, 3'd0, 32'hC0000000, 32'hBF800000, 32'd1, 5'h00);
        run("flt_zeros",    CMP, 1, 0, 3'd1, 32'h80000000, 32'h00000000, 32'd0, 5'h00);
        run("fle_zeros",    CMP, 1, 0, 3'd0, 32'h00000000, 32'h80000000, 32'd1, 5'h00);

        // int -> float
        run("i2f_rne_tie",  I2F, 1, 0, 3'd0, 32'h01000001, 32'h0, 32'h4B800000, 5'h01);
        run("i2f_rup",      I2F, 1, 0, 3'd3, 32'h01000001, 32'h0, 32'h4B800001, 5'h01);
        run("i2f_rdn_pos",  I2F, 1, 0, 3'd2, 32'h01000001, 32'h0, 32'h4B800000, 5'h01);
        run("i2f_min_int",  I2F, 1, 0, 3'd0, 32'h80000000, 32'h0, 32'hCF000000, 5'h00);
        run("i2f_minus1",   I2F, 1, 0, 3'd0, 32'hFFFFFFFF, 32'h0, 32'hBF800000, 5'h00);
        run("ui2f_rtz",     I2F, 1, 1, 3'd1, 32'hFFFFFFFF, 32'h0, 32'h4F7FFFFF, 5'h01);
        run("ui2f_rne",     I2F, 1, 1, 3'd0, 32'hFFFFFFFF, 32'h0, 32'h4F800000, 5'h01);
        run("i2f_zero",     I2F, 1, 0, 3'd0, 32'h00000000, 32'h0, 32'h00000000, 5'h00);

        // float -> int
        run("f2i_2p5_rne",  F2I, 1, 0, 3'd0, 32'h40200000, 32'h0, 32'd2, 5'h01);
        run("f2i_2p5_rmm",  F2I, 1, 0, 3'd4, 32'h40200000, 32'h0, 32'd3, 5'h01);
        run("f2i_m2p5_rdn", F2I, 1, 0, 3'd2, 32'hC0200000, 32'h0, 32'hFFFFFFFD, 5'h01);
        run("f2i_m2p5_rup", F2I, 1, 0, 3'd3, 32'hC0200000, 32'h0, 32'hFFFFFFFE, 5'h01);
        run("f2i_1p5_rtz",  F2I, 1, 0, 3'd1, 32'h3FC00000, 32'h0, 32'd1, 5'h01);
        run("f2i_2p31_sat", F2I, 1, 0, 3'd0, 32'h4F000000, 32'h0, 32'h7FFFFFFF, 5'h10);
        run("f2i_m2p31",    F2I, 1, 0, 3'd0, 32'hCF000000, 32'h0, 32'h80000000, 5'h00);
        run("f2i_neg_sat",  F2I, 1, 0, 3'd0, 32'hCF000001, 32'h0, 32'h80000000, 5'h10);
        run("f2i_negzero",  F2I, 1, 0, 3'd0, 32'h80000000, 32'h0, 32'h00000000, 5'h00);
        run("f2u_minus1",   F2I, 1, 1, 3'd0, 32'hBF800000, 32'h0, 32'h00000000, 5'h10);
        run("f2u_m0p25",    F2I, 1, 1, 3'd0, 32'hBE800000, 32'h0, 32'h00000000, 5'h01);
        run("f2u_nan",      F2I, 1, 1, 3'd0, 32'h7FC00000, 32'h0, 32'hFFFFFFFF, 5'h10);
        run("f2u_2p32_sat", F2I, 1, 1, 3'd0, 32'h4F800000, 32'h0, 32'hFFFFFFFF, 5'h10);
        run("f2i_nan",      F2I, 1, 0, 3'd0, 32'h7FC00000, 32'h0, 32'h7FFFFFFF, 5'h10);

        // select priority, no select, disabled
        run("prio_cmp",     3'b111, 1, 0, 3'd1, 32'h3F800000, 32'h40000000, 32'd1, 5'h00);
        run("prio_i2f",     3'b011, 1, 0, 3'd0, 32'h80000000, 32'h0, 32'hCF000000, 5'h00);
        run("no_select",    3'b000, 1, 0, 3'd0, 32'h40200000, 32'h0, 32'h0, 5'h00);
        run("disabled",     F2I, 0, 0, 3'd0, 32'h7FC00000, 32'h0, 32'h0, 5'h00);

        // async reset clears a registered result immediately
        run("pre_reset",    F2I, 1, 1, 3'd0, 32'h7FC00000, 32'h0, 32'hFFFFFFFF, 5'h10);
        #2;
        reset = 1'b1;
        #1;
        check("async_clear", 1'b0, 5'h00, 32'h0);

        // op presented while reset is held is discarded
        fcmp = 1'b0; fcvt_i2f = 1'b1; fcvt_f2i = 1'b0; enable = 1'b1;
        fcvt_op = 2'b00; rm = 3'd0; data1 = 32'hFFFFFFFF;
        @(posedge clock);
        #1;
        check("held_in_reset", 1'b0, 5'h00, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        run("after_reset",  I2F, 1, 0, 3'd0, 32'hFFFFFFFF, 32'h0, 32'hBF800000, 5'h00);

        enable = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
